// File: rtl/reflex_pixel_gen.sv
// Reaction-target pixel generator: red square on black, four modes, frame-rate blink.
// Optional crosshair overlay in modes 2/3 when RPG_CROSSHAIR_EN is defined.
module reflex_pixel_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned BOX_SIZE     = 32,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned COLOR_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   h_cnt,
  input  logic [CNT_W-1:0]   v_cnt,
  input  logic               valid,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   tgt_x,
  input  logic [CNT_W-1:0]   tgt_y,
  input  logic               tgt_load,
  output logic               tgt_ack,
  output logic [COLOR_W-1:0] vgaRed,
  output logic [COLOR_W-1:0] vgaGreen,
  output logic [COLOR_W-1:0] vgaBlue
);

  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned SW = CNT_W + 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [SW-1:0] BOX_W      = SW'(BOX_SIZE);
  localparam logic [SW-1:0] H_LIM      = SW'(H_ACTIVE);
  localparam logic [SW-1:0] V_LIM      = SW'(V_ACTIVE);

  logic               cond_q, cond_d;
  logic               pend_q, pend_d;
  logic [1:0]         pend_mode_q, pend_mode_d;
  logic [CNT_W-1:0]   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [1:0]         act_mode_q, act_mode_d;
  logic [CNT_W-1:0]   act_x_q, act_x_d, act_y_q, act_y_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic               ack_q, ack_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic               cond, frame_tick, in_active, in_box;
  logic [SW-1:0]      h_ext, v_ext, x_ext, y_ext;

  // Frame tick, double-buffered target/mode and blink timebase
  always_comb begin
    cond        = (v_ext == V_LIM) && (h_cnt == '0);
    frame_tick  = cond && !cond_q;
    cond_d      = cond;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    act_mode_d  = act_mode_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    ack_d       = frame_tick && pend_q;

    if (frame_tick && pend_q) begin
      act_mode_d = pend_mode_q;
      act_x_d    = pend_x_q;
      act_y_d    = pend_y_q;
      pend_d     = 1'b0;
    end
    // A load coinciding with the tick lands in pending and waits for the next tick
    if (tgt_load) begin
      pend_mode_d = mode;
      pend_x_d    = tgt_x;
      pend_y_d    = tgt_y;
      pend_d      = 1'b1;
    end

    if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Colour selection; sums are one bit wider so the box never wraps
  always_comb begin
    h_ext     = {1'b0, h_cnt};
    v_ext     = {1'b0, v_cnt};
    x_ext     = {1'b0, act_x_q};
    y_ext     = {1'b0, act_y_q};
    in_active = valid && (h_ext < H_LIM) && (v_ext < V_LIM);
    in_box    = (h_ext >= x_ext) && (h_ext < x_ext + BOX_W) &&
                (v_ext >= y_ext) && (v_ext < y_ext + BOX_W);
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;

    case (act_mode_q)
      2'd1: begin
        red_d   = '1;
        green_d = '1;
        blue_d  = '1;
      end
      2'd2: if (in_box) red_d = '1;
      2'd3: if (in_box && blink_on_q) red_d = '1;
      default: ;
    endcase
`ifdef RPG_CROSSHAIR_EN
    if (act_mode_q[1] && ((h_ext == SW'(H_ACTIVE / 2)) || (v_ext == SW'(V_ACTIVE / 2)))) begin
      red_d   = '1;
      green_d = '1;
      blue_d  = '1;
    end
`endif
    if (!in_active) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_mode_q <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      act_mode_q  <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      ack_q       <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      cond_q      <= cond_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      act_mode_q  <= act_mode_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      ack_q       <= ack_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign tgt_ack  = ack_q;
  assign vgaRed   = red_q;
  assign vgaGreen = green_q;
  assign vgaBlue  = blue_q;

endmodule

// File: tb/tb_reflex_pixel_gen.sv
// Self-checking bench for reflex_pixel_gen (BLINK_FRAMES=2, 640x480).
module tb_reflex_pixel_gen;

  localparam logic [11:0] BLK = 12'h000;
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] WHT = 12'hFFF;
`ifdef RPG_CROSSHAIR_EN
  localparam logic [11:0] XH = 12'hFFF;
`else
  localparam logic [11:0] XH = 12'h000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_cnt, v_cnt, tgt_x, tgt_y;
  logic       valid, tgt_load, tgt_ack;
  logic [1:0] mode;
  logic [3:0] vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;
  int ticks = 0;
  bit prev_cond = 1'b0;

  typedef struct {
    logic [11:0] rgb;
    bit          ack;
    string       nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          h;
    int          v;
    bit          val;
    logic [11:0] rgb;
    string       nm;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  reflex_pixel_gen #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .mode(mode), .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_load(tgt_load),
    .tgt_ack(tgt_ack), .vgaRed(vga_r), .vgaGreen(vga_g), .vgaBlue(vga_b)
  );

  task automatic chk_rgb(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rgb: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ack(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ack: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, queue expectation, compare after the edge
  task automatic step(input int h, input int v, input bit val, input bit ld, input int md,
                      input int x, input int y, input logic [11:0] erg, input bit eack,
                      input string nm);
    exp_t e;
    h_cnt = 10'(h); v_cnt = 10'(v); valid = val;
    tgt_load = ld; mode = 2'(md); tgt_x = 10'(x); tgt_y = 10'(y);
    sb.push_back('{rgb: erg, ack: eack, nm: nm});
    if (v == 480 && h == 0 && !prev_cond) ticks++;
    prev_cond = (v == 480 && h == 0);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk_rgb(e.nm, {vga_r, vga_g, vga_b}, e.rgb);
    chk_ack(e.nm, tgt_ack, e.ack);
    tgt_load = 1'b0;
  endtask

  task automatic px(input int h, input int v, input logic [11:0] erg, input string nm);
    step(h, v, 1'b1, 1'b0, 0, 0, 0, erg, 1'b0, nm);
  endtask

  task automatic tick(input bit eack, input string nm);
    step(0, 480, 1'b0, 1'b0, 0, 0, 0, BLK, eack, nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    h_cnt = '0; v_cnt = '0; valid = 1'b0; tgt_load = 1'b0;
    mode = '0; tgt_x = '0; tgt_y = '0;
    ticks = 0; prev_cond = 1'b0;
    @(posedge clk); #3;
    chk_rgb("reset_val", {vga_r, vga_g, vga_b}, BLK);
    chk_ack("reset_val", tgt_ack, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{100, 50, 1'b1, RED, "box_tl"};
    tbl[1] = '{131, 81, 1'b1, RED, "box_br"};
    tbl[2] = '{99,  50, 1'b1, BLK, "box_left_out"};
    tbl[3] = '{132, 81, 1'b1, BLK, "box_right_out"};
    tbl[4] = '{100, 49, 1'b1, BLK, "box_top_out"};
    tbl[5] = '{131, 82, 1'b1, BLK, "box_bot_out"};
    tbl[6] = '{115, 65, 1'b0, BLK, "box_invalid"};
    tbl[7] = '{115, 65, 1'b1, RED, "box_mid"};
    tbl[8] = '{0,   0,  1'b1, BLK, "field_black"};
    tbl[9] = '{320, 10, 1'b1, XH,  "crosshair_v"};

    do_reset();

    for (int v = 0; v < 480; v += 7)
      for (int h = 0; h < 640; h += 13)
        px(h, v, BLK, "m0_sweep");
    px(639, 479, BLK, "m0_corner");

    // Mode 1 requested mid-frame, applied at the tick
    step(200, 100, 1'b1, 1'b1, 1, 0, 0, BLK, 1'b0, "m1_load");
    px(300, 200, BLK, "m1_pending");
    px(639, 479, BLK, "m1_pending_end");
    tick(1'b1, "m1_ack");
    tick(1'b0, "tick_hold1");
    tick(1'b0, "tick_hold2");
    px(0, 0, WHT, "m1_first");
    px(639, 479, WHT, "m1_last");
    px(650, 10, BLK, "m1_h650");
    step(10, 10, 1'b0, 1'b0, 0, 0, 0, BLK, 1'b0, "m1_invalid");
    px(320, 480, BLK, "m1_v480");
    px(5, 5, WHT, "m1_after");

    // Mode 2, target (100,50)
    step(400, 300, 1'b1, 1'b1, 2, 100, 50, WHT, 1'b0, "m2_load");
    tick(1'b1, "m2_ack");
    for (int i = 0; i < 10; i++)
      step(tbl[i].h, tbl[i].v, tbl[i].val, 1'b0, 0, 0, 0, tbl[i].rgb, 1'b0, tbl[i].nm);
    px(10, 240, XH, "crosshair_h");

    // Target clipped at the bottom-right corner
    step(0, 0, 1'b1, 1'b1, 2, 620, 470, BLK, 1'b0, "edge_load");
    tick(1'b1, "edge_ack");
    px(639, 479, RED, "edge_corner");
    px(620, 470, RED, "edge_tl");
    px(640, 479, BLK, "edge_h640");
    px(619, 470, BLK, "edge_left_out");
    px(639, 0, BLK, "edge_wrap_y");
    px(5, 470, BLK, "edge_wrap_x");
    px(620, 1, BLK, "edge_wrap_y2");

    // Second load coincides with the tick and waits one more frame
    step(50, 50, 1'b1, 1'b1, 2, 10, 10, BLK, 1'b0, "dbl_load1");
    step(0, 480, 1'b0, 1'b1, 2, 200, 200, BLK, 1'b1, "dbl_tick_ack");
    px(10, 10, RED, "dbl_first");
    px(200, 200, BLK, "dbl_not_yet");
    tick(1'b1, "dbl_second_ack");
    px(200, 200, RED, "dbl_second");
    px(10, 10, BLK, "dbl_first_gone");
    tick(1'b0, "dbl_no_extra_ack");

    // Last write wins, single ack
    step(0, 0, 1'b1, 1'b1, 2, 300, 300, BLK, 1'b0, "lww_load1");
    step(1, 0, 1'b1, 1'b1, 2, 400, 400, BLK, 1'b0, "lww_load2");
    tick(1'b1, "lww_ack");
    px(400, 400, RED, "lww_new");
    px(300, 300, BLK, "lww_old");
    tick(1'b0, "lww_no_extra_ack");

    // Asynchronous reset mid-frame
    px(410, 410, RED, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    chk_rgb("async_reset", {vga_r, vga_g, vga_b}, BLK);
    chk_ack("async_reset", tgt_ack, 1'b0);
    do_reset();
    px(410, 410, BLK, "post_reset_m0");

    // Blinking target: two frames on, two off
    step(5, 5, 1'b1, 1'b1, 3, 100, 50, BLK, 1'b0, "m3_load");
    tick(1'b1, "m3_ack");
    for (int f = 1; f <= 5; f++) begin
      px(110, 60, (((ticks / 2) % 2) == 0) ? RED : BLK, "blink_box");
      px(99, 60, BLK, "blink_out");
      tick(1'b0, "blink_tick");
    end

    // Load during a held tick condition is not applied until the next real tick
    step(0, 480, 1'b0, 1'b1, 2, 100, 50, BLK, 1'b0, "hold_load");
    px(110, 60, (((ticks / 2) % 2) == 0) ? RED : BLK, "hold_still_m3");
    tick(1'b1, "hold_load_ack");
    px(110, 60, RED, "m2_ignores_blink");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
